// File: rtl/gf2m_pkg.sv
// Shared GF(2^163) field constants and FSM state encoding for the field arithmetic units.
package gf2m_pkg;

    localparam int unsigned M  = 163;
    localparam int unsigned CW = 8;

    // x^163 + x^7 + x^6 + x^3 + 1
    localparam logic [M:0] POLY = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gf2m_sqr_reduce.sv
// Combinational GF(2^M) squarer: bit-interleave spread followed by modular reduction.
module gf2m_sqr_reduce
    import gf2m_pkg::*;
(
    input  logic [M-1:0] a,
    output logic [M-1:0] r
);

    localparam int unsigned SW = 2 * M - 1;
    localparam logic [SW-1:0] POLY_X = SW'(POLY);

    logic [SW-1:0] s;

    // High-to-low reduction so folded-in bits are themselves reduced later in the loop.
    always_comb begin
        s = '0;
        for (int i = 0; i < int'(M); i++) begin
            s[2*i] = a[i];
        end
        for (int i = int'(SW) - 1; i >= int'(M); i--) begin
            if (s[i]) begin
                s = s ^ (POLY_X << (i - int'(M)));
            end
        end
        r = s[M-1:0];
    end

endmodule

// File: rtl/gf2m_sqrt_iter.sv
// Iterative GF(2^M) square root: sqrt(a) = a^(2^(M-1)) via M-1 squarings, one per clock.
module gf2m_sqrt_iter
    import gf2m_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a_in,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] sqrt_out
);

    state_t          state_q, state_d;
    logic [M-1:0]    acc_q, acc_d, acc_sq;
    logic [M-1:0]    sqrt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_d, done_d;

    gf2m_sqr_reduce u_sqr (
        .a (acc_q),
        .r (acc_sq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sqrt_out <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            sqrt_out <= sqrt_d;
        end
    end

    // The done-pulse cycle still belongs to the completing operation, so start is not taken there.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sqrt_d  = sqrt_out;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !done) begin
                    acc_d   = a_in;
                    cnt_d   = CW'(M - 1);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_sq;
                cnt_d  = cnt_q - CW'(1);
                busy_d = 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                sqrt_d  = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gf2m_sqrt_iter.sv
// Directed and random checks of gf2m_sqrt_iter against an independent shift-and-add field model.
module tb_gf2m_sqrt_iter;
    import gf2m_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [M-1:0] a_in;
    logic         busy;
    logic         done;
    logic [M-1:0] sqrt_out;

    int tests = 0;
    int fails = 0;

    localparam int LAT   = int'(M) + 1;
    localparam int BUSYN = int'(M) - 1;

    typedef struct packed {
        logic [M-1:0] a;
        logic [M-1:0] e;
    } vec_t;

    gf2m_sqrt_iter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .busy     (busy),
        .done     (done),
        .sqrt_out (sqrt_out)
    );

    always #5 clk = ~clk;

    // Shift-and-add multiply with per-step reduction.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M:0] acc;
        acc = '0;
        for (int i = int'(M) - 1; i >= 0; i--) begin
            acc = acc << 1;
            if (acc[M]) acc = acc ^ POLY;
            if (y[i]) acc = acc ^ {1'b0, x};
        end
        return acc[M-1:0];
    endfunction

    function automatic logic [M-1:0] model_sqrt(input logic [M-1:0] x);
        logic [M-1:0] t;
        t = x;
        for (int i = 0; i < int'(M) - 1; i++) t = gf_mul(t, t);
        return t;
    endfunction

    task automatic check_v(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from idle; returns result, done latency, busy cycle count and hold status.
    task automatic run_op(input logic [M-1:0] a, output logic [M-1:0] r,
                          output int lat, output int bcnt, output bit held);
        logic [M-1:0] prev;
        prev  = sqrt_out;
        r     = '0;
        held  = 1'b1;
        bcnt  = 0;
        a_in  = a;
        start = 1'b1;
        step();
        start = 1'b0;
        lat   = 1;
        while (lat < 400) begin
            if (done) begin
                r = sqrt_out;
                break;
            end
            if (busy) bcnt++;
            if (sqrt_out !== prev) held = 1'b0;
            step();
            lat++;
        end
        step();
    endtask

    initial begin
        vec_t         tbl [8];
        logic [M-1:0] r, r1, a, a1;
        int           lat, bcnt, cyc, d1, d2, ndone;
        bit           held, stable;

        tbl[0] = '{a: M'(0),        e: M'(0)};
        tbl[1] = '{a: M'(1),        e: M'(1)};
        tbl[2] = '{a: M'('h4),      e: M'('h2)};
        tbl[3] = '{a: M'('h14),     e: M'('h6)};
        tbl[4] = '{a: M'('h10),     e: M'('h4)};
        tbl[5] = '{a: M'('h40),     e: M'('h8)};
        tbl[6] = '{a: M'('h55),     e: M'('hF)};
        tbl[7] = '{a: M'(1) << 162, e: M'(1) << 81};

        // Reset dominates a simultaneous start request.
        rst   = 1'b1;
        start = 1'b1;
        a_in  = M'(1);
        repeat (3) step();
        start = 1'b0;
        rst   = 1'b0;
        step();
        check_i("reset_busy", int'(busy), 0);
        check_i("reset_done", int'(done), 0);
        check_v("reset_sqrt", sqrt_out, '0);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, r, lat, bcnt, held);
            check_v($sformatf("vec%0d_result", i), r, tbl[i].e);
            check_i($sformatf("vec%0d_latency", i), lat, LAT);
            check_i($sformatf("vec%0d_busy_cycles", i), bcnt, BUSYN);
            check_i($sformatf("vec%0d_hold", i), int'(held), 1);
        end

        for (int n = 0; n < 100; n++) begin
            a = M'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            run_op(a, r, lat, bcnt, held);
            check_v($sformatf("rand%0d_square_back", n), gf_mul(r, r), a);
            check_v($sformatf("rand%0d_model", n), r, model_sqrt(a));
        end

        // Starts during RUN are dropped; start right after done is accepted.
        a1    = M'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        a_in  = a1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc   = 1;
        d1    = -1;
        r1    = '0;
        while (cyc < 400) begin
            if (cyc == 10 || cyc == 100) begin
                a_in  = ~a1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                d1 = cyc;
                r1 = sqrt_out;
                break;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check_i("ignore_start_latency", d1, LAT);
        check_v("ignore_start_result", r1, model_sqrt(a1));
        step();
        run_op(M'('h14), r, lat, bcnt, held);
        check_v("b2b_result", r, M'('h6));
        check_i("b2b_latency", lat, LAT);

        // Reset in the middle of RUN aborts without a done pulse.
        a_in  = a1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (49) step();
        check_i("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_i("abort_busy", int'(busy), 0);
        check_i("abort_done", int'(done), 0);
        check_v("abort_sqrt", sqrt_out, '0);
        ndone = 0;
        for (int k = 0; k < 200; k++) begin
            if (done || busy) ndone++;
            step();
        end
        check_i("abort_quiet", ndone, 0);
        run_op(M'('h14), r, lat, bcnt, held);
        check_v("after_abort_result", r, M'('h6));

        // Start held high: one operation per LAT+1 cycles, output stable between pulses.
        a_in   = M'('h55);
        start  = 1'b1;
        step();
        cyc    = 1;
        d1     = -1;
        d2     = -1;
        r1     = '0;
        stable = 1'b1;
        while (cyc < 600 && d2 < 0) begin
            if (done) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    r1 = sqrt_out;
                end else begin
                    d2 = cyc;
                end
            end else if (d1 >= 0 && sqrt_out !== r1) begin
                stable = 1'b0;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check_i("held_first_done", d1, LAT);
        check_i("held_period", d2 - d1, LAT + 1);
        check_v("held_result", r1, M'('hF));
        check_i("held_stable", int'(stable), 1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
